// File: rtl/spi_page_prog_seq.sv
// Page-program sequencer for the spi_cmd engine.
// Collects a flash address and 1..256 page bytes, then issues WRITE ENABLE,
// PAGE PROGRAM and READ STATUS (polled until WIP clears or the poll budget
// runs out) through spi_cmd's trigger/busy handshake.
module spi_page_prog_seq #(
  parameter int POLL_MAX = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [23:0]   addr,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  input  logic          wr_last,
  output logic          wr_ready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    status_out,
  output logic          cmd_trigger,
  input  logic          cmd_busy,
  output logic [8:0]    cmd_data_in_count,
  output logic [2079:0] cmd_data_in,
  output logic          cmd_data_out_count,
  input  logic [7:0]    cmd_data_out,
  output logic          cmd_quad
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WREN_ISSUE,
    S_WREN_WAIT,
    S_PP_ISSUE,
    S_PP_WAIT,
    S_RDSR_ISSUE,
    S_RDSR_WAIT,
    S_CHECK
  } state_t;

  localparam logic [7:0]  OP_WREN   = 8'h06;
  localparam logic [7:0]  OP_PP     = 8'h02;
  localparam logic [7:0]  OP_RDSR   = 8'h05;
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);

  state_t          state, state_next;
  logic [2079:0]   page_buf;
  logic [8:0]      byte_cnt;
  logic [15:0]     poll_cnt;
  logic            start_acc;
  logic            byte_acc;
  logic            load_end;

  assign wr_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign cmd_quad  = 1'b0;
  assign start_acc = (state == S_IDLE) && start;
  assign byte_acc  = wr_ready && wr_valid;
  // The 256th byte closes the page even without wr_last.
  assign load_end  = byte_acc && (wr_last || (byte_cnt == 9'd255));

  // Next-state logic for the command sequence.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_next = state;
    case (state)
      S_IDLE:       if (start)     state_next = S_LOAD;
      S_LOAD:       if (load_end)  state_next = S_WREN_ISSUE;
      S_WREN_ISSUE: if (cmd_busy)  state_next = S_WREN_WAIT;
      S_WREN_WAIT:  if (!cmd_busy) state_next = S_PP_ISSUE;
      S_PP_ISSUE:   if (cmd_busy)  state_next = S_PP_WAIT;
      S_PP_WAIT:    if (!cmd_busy) state_next = S_RDSR_ISSUE;
      S_RDSR_ISSUE: if (cmd_busy)  state_next = S_RDSR_WAIT;
      S_RDSR_WAIT:  if (!cmd_busy) state_next = S_CHECK;
      S_CHECK: begin
        if (!status_out[0] || (poll_cnt == POLL_LAST)) state_next = S_IDLE;
        else                                           state_next = S_RDSR_ISSUE;
      end
      default:                     state_next = S_IDLE;
    endcase
  end

  // Command frame presented to spi_cmd; constant for each ISSUE/WAIT pair.
  always_comb begin
    cmd_data_in        = '0;
    cmd_data_in_count  = 9'd0;
    cmd_data_out_count = 1'b0;
    case (state)
      S_WREN_ISSUE, S_WREN_WAIT: begin
        cmd_data_in       = {2072'b0, OP_WREN};
        cmd_data_in_count = 9'd1;
      end
      S_PP_ISSUE, S_PP_WAIT: begin
        cmd_data_in       = page_buf;
        cmd_data_in_count = byte_cnt + 9'd4;
      end
      S_RDSR_ISSUE, S_RDSR_WAIT: begin
        cmd_data_in        = {2072'b0, OP_RDSR};
        cmd_data_in_count  = 9'd1;
        cmd_data_out_count = 1'b1;
      end
      default: ;
    endcase
  end

  // Page buffer: header loaded on start, data bytes shifted in below it.
  // NOTE: this wide datapath register has no reset; it is always reloaded
  // by an accepted start before anything reads it.
  always_ff @(posedge clk) begin
    if (start_acc)     page_buf <= {2048'b0, OP_PP, addr};
    else if (byte_acc) page_buf <= {page_buf[2071:0], wr_data};
  end

  // Control state, counters, status capture and handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state       <= S_IDLE;
      byte_cnt    <= 9'd0;
      poll_cnt    <= 16'd0;
      status_out  <= 8'h00;
      error       <= 1'b0;
      done        <= 1'b0;
      cmd_trigger <= 1'b0;
    end else begin
      state       <= state_next;
      done        <= (state == S_CHECK) && !status_out[0];
      cmd_trigger <= (state_next == S_WREN_ISSUE) || (state_next == S_PP_ISSUE) ||
                     (state_next == S_RDSR_ISSUE);
      if (start_acc) begin
        byte_cnt <= 9'd0;
        error    <= 1'b0;
      end
      if (byte_acc) byte_cnt <= byte_cnt + 9'd1;
      if ((state == S_PP_WAIT) && !cmd_busy) poll_cnt <= 16'd0;
      if ((state == S_RDSR_WAIT) && !cmd_busy) status_out <= cmd_data_out;
      if ((state == S_CHECK) && status_out[0]) begin
        if (poll_cnt == POLL_LAST) error    <= 1'b1;
        else                       poll_cnt <= poll_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_page_prog_seq.sv
// Randomized scoreboard bench for spi_page_prog_seq with a behavioural
// spi_cmd responder and a transaction-level reference model.
`timescale 1ns/1ps
module tb_spi_page_prog_seq;

  localparam int TB_POLL_MAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [23:0]   addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_last = 1'b0;
  logic          wr_ready, busy, done, error;
  logic [7:0]    status_out;
  logic          cmd_trigger;
  logic          cmd_busy = 1'b0;
  logic [8:0]    cmd_data_in_count;
  logic [2079:0] cmd_data_in;
  logic          cmd_data_out_count;
  logic [7:0]    cmd_data_out = '0;
  logic          cmd_quad;

  spi_page_prog_seq #(.POLL_MAX(TB_POLL_MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .busy(busy), .done(done), .error(error), .status_out(status_out),
    .cmd_trigger(cmd_trigger), .cmd_busy(cmd_busy),
    .cmd_data_in_count(cmd_data_in_count), .cmd_data_in(cmd_data_in),
    .cmd_data_out_count(cmd_data_out_count), .cmd_data_out(cmd_data_out),
    .cmd_quad(cmd_quad)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;   // 0 WREN, 1 PP, 2 RDSR
    logic [2079:0] data;
    int            count;
  } exp_cmd_t;

  typedef struct {
    bit         done;
    bit         err;
    logic [7:0] status;
  } exp_end_t;

  exp_cmd_t   cmd_q[$];
  exp_end_t   end_q[$];
  logic [7:0] st_q[$];
  logic [7:0] plan_bytes[$];
  logic [7:0] plan_st[$];

  int total = 0;
  int bad = 0;
  int frames_seen = 0;
  int done_pulses = 0;
  int exp_dones = 0;
  bit abort = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reports the lowest differing 32-bit word of a frame.
  task automatic check_wide(input string name, input logic [2079:0] act, input logic [2079:0] exp);
    int w = 0;
    for (int i = 64; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
    check($sformatf("%s.w%0d", name, w), 64'(act[w*32 +: 32]), 64'(exp[w*32 +: 32]));
  endtask

  // spi_cmd responder: takes the trigger, goes busy for a while, returns a status byte.
  int   m_phase = 0;
  int   m_cnt = 0;
  logic m_out = 1'b0;
  always @(negedge clk) begin : spi_model
    if (reset) begin
      m_phase = 0;
      cmd_busy = 1'b0;
    end else begin
      case (m_phase)
        0: if (cmd_trigger) begin
             m_phase = 1;
             m_cnt = int'($urandom % 3);
             m_out = cmd_data_out_count;
           end
        1: if (m_cnt == 0) begin
             cmd_busy = 1'b1;
             m_phase = 2;
             m_cnt = 2 + int'($urandom % 4);
           end else m_cnt--;
        default: if (m_cnt <= 1) begin
             cmd_busy = 1'b0;
             m_phase = 0;
             if (m_out) cmd_data_out = (st_q.size() > 0) ? st_q.pop_front() : 8'h00;
             else       cmd_data_out = 8'($urandom);
           end else m_cnt--;
      endcase
    end
  end

  // Command monitor: every new trigger must match the next expected frame.
  logic prev_trig = 1'b0;
  always @(negedge clk) begin : cmd_mon
    exp_cmd_t      e;
    logic [2079:0] mask;
    string         nm;
    if (!reset && cmd_trigger && !prev_trig) begin
      frames_seen++;
      if (cmd_q.size() == 0) begin
        check("unexpected_cmd_count", 64'(cmd_data_in_count), 64'd0);
      end else begin
        e = cmd_q.pop_front();
        nm = (e.kind == 0) ? "wren" : (e.kind == 1) ? "pp" : "rdsr";
        mask = (e.kind == 1) ? ~({2080{1'b1}} << (e.count * 8)) : {2080{1'b1}};
        check({nm, "_count"}, 64'(cmd_data_in_count), 64'(e.count));
        check({nm, "_out_count"}, 64'(cmd_data_out_count), 64'(e.kind == 2));
        check({nm, "_quad"}, 64'(cmd_quad), 64'd0);
        check_wide({nm, "_data"}, cmd_data_in & mask, e.data);
      end
    end
    prev_trig = cmd_trigger;
  end

  // End monitor: when busy drops, compare the transaction outcome.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin : end_mon
    exp_end_t e;
    if (done) done_pulses++;
    if (prev_busy && !busy && !abort && !reset) begin
      if (end_q.size() == 0) begin
        check("unexpected_end_done", 64'(done), 64'd0);
      end else begin
        e = end_q.pop_front();
        check("end_done", 64'(done), 64'(e.done));
        check("end_error", 64'(error), 64'(e.err));
        check("end_status", 64'(status_out), 64'(e.status));
        check("cmds_left", 64'(cmd_q.size()), 64'd0);
      end
    end
    prev_busy = busy;
  end

  // Reference model + driver for one transaction.
  task automatic run_txn(input logic [23:0] a, input int last_idx, input bit noise,
                         input bit reset_in_pp);
    int            acc;
    logic [2079:0] v;
    exp_cmd_t      c;
    exp_end_t      ee;
    logic [7:0]    s;
    int            idx;
    int            g;
    int            base;

    acc = (last_idx >= 0 && last_idx < 256) ? last_idx + 1 : 256;
    v = '0;
    v = {v[2071:0], 8'h02};
    v = {v[2071:0], a[23:16]};
    v = {v[2071:0], a[15:8]};
    v = {v[2071:0], a[7:0]};
    for (int i = 0; i < acc; i++) v = {v[2071:0], plan_bytes[i]};
    c.kind = 0; c.data = {2072'b0, 8'h06}; c.count = 1; cmd_q.push_back(c);
    c.kind = 1; c.data = v;                c.count = acc + 4; cmd_q.push_back(c);
    ee.done = 1'b0; ee.err = 1'b0; ee.status = 8'h00;
    for (int i = 0; i < TB_POLL_MAX; i++) begin
      s = (i < plan_st.size()) ? plan_st[i] : 8'h00;
      c.kind = 2; c.data = {2072'b0, 8'h05}; c.count = 1; cmd_q.push_back(c);
      st_q.push_back(s);
      ee.status = s;
      if (!s[0]) begin ee.done = 1'b1; break; end
      if (i == TB_POLL_MAX - 1) ee.err = 1'b1;
    end
    end_q.push_back(ee);
    if (!reset_in_pp && ee.done) exp_dones++;
    base = frames_seen;

    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
    start = 1'b1; addr = a;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_clears_error", 64'(error), 64'd0);

    idx = 0; g = 0;
    while (idx < acc && g < 5000) begin
      if (noise && ($urandom % 4 == 0)) begin
        wr_valid = 1'b0;
      end else begin
        wr_valid = 1'b1;
        wr_data  = plan_bytes[idx];
        wr_last  = (idx == last_idx);
      end
      if (wr_valid && wr_ready) idx++;
      @(negedge clk);
      g++;
    end
    if (g >= 5000) check("load_timeout", 64'(idx), 64'(acc));
    wr_valid = (plan_bytes.size() > acc);
    if (plan_bytes.size() > acc) begin
      wr_data = plan_bytes[acc];
      wr_last = 1'b0;
    end
    check("wr_ready_after_load", 64'(wr_ready), 64'd0);

    if (reset_in_pp) begin
      g = 0;
      while (!(frames_seen == base + 2 && cmd_busy && !cmd_trigger) && g < 2000) begin
        @(negedge clk); #1;
        g++;
      end
      if (g >= 2000) check("pp_wait_timeout", 64'(g), 64'd0);
      abort = 1'b1;
      reset = 1'b1;
      @(negedge clk); #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_trigger", 64'(cmd_trigger), 64'd0);
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      reset = 1'b0;
      wr_valid = 1'b0;
      cmd_q.delete(); end_q.delete(); st_q.delete();
      repeat (2) @(negedge clk);
      abort = 1'b0;
    end else begin
      g = 0;
      while (g < 4000) begin
        @(negedge clk);
        start = 1'b0;
        if (!busy) break;
        if (noise) begin
          start    = ($urandom % 5 == 0);
          addr     = 24'($urandom);
          wr_valid = $urandom % 2;
          wr_data  = 8'($urandom);
          wr_last  = $urandom % 2;
        end
        g++;
      end
      start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      if (g >= 4000) check("busy_timeout", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic rand_plan(input int nb);
    int ns;
    plan_bytes.delete();
    for (int i = 0; i < nb; i++) plan_bytes.push_back(8'($urandom));
    plan_st.delete();
    ns = 1 + int'($urandom % 5);
    for (int i = 0; i < ns; i++)
      plan_st.push_back((i == ns - 1) ? 8'($urandom) : (8'($urandom) | 8'h01));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int nb;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    check("reset_wr_ready", 64'(wr_ready), 64'd0);
    check("reset_trigger", 64'(cmd_trigger), 64'd0);
    check("reset_status", 64'(status_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte, immediate success.
    plan_bytes = '{8'hA5};
    plan_st = '{8'h00};
    run_txn(24'h012345, 0, 1'b0, 1'b0);

    // 300 bytes without wr_last: auto-terminates after 256.
    plan_bytes.delete();
    for (int i = 0; i < 300; i++) plan_bytes.push_back(8'(i));
    plan_st = '{8'h00};
    run_txn(24'($urandom), -1, 1'b0, 1'b0);

    // wr_last before the page limit, surplus bytes offered afterwards.
    rand_plan(270);
    run_txn(24'($urandom), 200, 1'b0, 1'b0);

    // Four polls ending in success.
    rand_plan(3);
    plan_st = '{8'h03, 8'h03, 8'h01, 8'h00};
    run_txn(24'h00FFFE, 2, 1'b0, 1'b0);

    // Stuck busy: poll budget exhausted, error set, no done.
    rand_plan(2);
    plan_st = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_txn(24'h123456, 1, 1'b0, 1'b0);

    // Next start clears error (checked on start).
    rand_plan(4);
    plan_st = '{8'h01, 8'h00};
    run_txn(24'hABCDEF, 3, 1'b1, 1'b0);

    // Reset during PP_WAIT, then a fresh transaction begins with WREN.
    rand_plan(8);
    plan_st = '{8'h01, 8'h00};
    run_txn(24'h0A0B0C, 7, 1'b0, 1'b1);
    rand_plan(5);
    run_txn(24'h0D0E0F, 4, 1'b1, 1'b0);

    // Randomized transactions with start/wr_valid noise while busy.
    for (int t = 0; t < 12; t++) begin
      nb = 1 + int'($urandom % 40);
      rand_plan(nb);
      run_txn(24'($urandom), nb - 1, 1'b1, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("final_cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check("final_end_q_empty", 64'(end_q.size()), 64'd0);
    check("done_pulse_count", 64'(done_pulses), 64'(exp_dones));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_page_prog_seq.md
Name: spi_page_prog_seq

Overview:
- Command sequencer that sits directly upstream of the SPI command engine, spi_cmd. It drives spi_cmd's trigger, data_in, data_in_count, data_out_count and quad inputs, and consumes spi_cmd's busy and data_out.
- Accepts a start request with a 24-bit flash address, then a byte stream of 1..256 page bytes.
- Runs the full page-program transaction autonomously:
  - WRITE ENABLE (0x06).
  - PAGE PROGRAM (0x02 + addr + data).
  - READ STATUS (0x05) polling until WIP (bit 0) clears, or the poll count runs out.

Parameters:
- POLL_MAX, 1024: maximum number of RDSR polls before error is declared; range 1..65535.

Ports:
- clk  input  1  system clock, shared with spi_cmd.
- reset  input  1  synchronous, active-high reset; the same net resets spi_cmd.
- start  input  1  begin a transaction; sampled only in IDLE.
- addr  input  24  flash byte address, captured on the start cycle.
- wr_data  input  8  page data byte.
- wr_valid  input  1  wr_data valid.
- wr_last  input  1  marks the final page byte; qualified by wr_valid.
- wr_ready  output  1  byte accepted on wr_valid && wr_ready.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse: program finished with WIP=0.
- error  output  1  sticky poll-timeout flag, cleared by the next accepted start.
- status_out  output  8  last status byte read.
- cmd_trigger  output  1  to spi_cmd trigger.
- cmd_busy  input  1  from spi_cmd busy.
- cmd_data_in_count  output  9  to spi_cmd data_in_count.
- cmd_data_in  output  2080  to spi_cmd data_in.
- cmd_data_out_count  output  1  to spi_cmd data_out_count.
- cmd_data_out  input  8  from spi_cmd data_out.
- cmd_quad  output  1  tied 0; this block uses single-IO only.

Behaviour:
- Reset values: busy=0, done=0, error=0, wr_ready=0, cmd_trigger=0, status_out=0x00, state=IDLE, byte count N=0, poll count=0.
- Reset mid-transaction returns to IDLE immediately; no partial command is re-issued.
- The spi_cmd framing is MSB-first from bit data_in_count*8-1 down to bit 0.
- Page buffer: a 2080-bit register.
  - On accepted start: buffer[31:0] = {0x02, addr}, N=0.
  - On each accepted byte: buffer shifts left 8, buffer[7:0] = wr_data, N = N+1.
  - After N bytes the header occupies bits [8N+31:8N].
- cmd_data_in and counts, by phase:
  - WREN: {2072'b0, 0x06}, count 1, out_count 0.
  - PP: buffer, count N+4, out_count 0.
  - RDSR: {2072'b0, 0x05}, count 1, out_count 1.
  - These values are stable for the whole phase.
- Issue/complete handshake, identical for every command:
  - ISSUE state: cmd_trigger is registered high and held until cmd_busy=1 is sampled.
  - Then cmd_trigger goes low and the FSM moves to WAIT.
  - WAIT: the command is complete on the first cycle with cmd_busy=0.
  - cmd_busy=1 held after reset simply stalls ISSUE.
- States:
  - IDLE: busy=0. On start, capture addr, clear error, go to LOAD.
  - LOAD: wr_ready=1. Advance to WREN_ISSUE on an accepted byte with wr_last, or on the 256th accepted byte (auto-terminate; wr_ready drops, and excess bytes stay unaccepted).
  - WREN_ISSUE -> WREN_WAIT.
  - WREN_WAIT -> PP_ISSUE.
  - PP_ISSUE -> PP_WAIT.
  - PP_WAIT -> RDSR_ISSUE, with poll count = 0.
  - RDSR_ISSUE -> RDSR_WAIT.
  - RDSR_WAIT, on completion: status_out <= cmd_data_out, go to CHECK.
  - CHECK:
    - status_out[0]=0: pulse done, go to IDLE.
    - else if poll count = POLL_MAX-1: set error, go to IDLE with no done.
    - else increment poll count, go to RDSR_ISSUE.
- wr_ready=0 outside LOAD; wr_valid is ignored there. start is ignored while busy=1.
- busy=1 from the cycle after an accepted start until the cycle after CHECK exits.
- No page-boundary check: addr[7:0]+N>256 is passed through unchanged, and the flash wraps within the page.

Test Plan:
- start, addr=0x012345, one byte 0xA5 with wr_last; spi_cmd model returns status 0x00:
  - WREN frame is 0x06 with count 1.
  - PP frame is count 5, cmd_data_in[39:0]=0x02012345A5.
  - RDSR frame is count 1, out_count 1.
  - One done pulse; status_out=0x00.
- Stream 300 bytes 0x00..0xFF..., no wr_last:
  - wr_ready low after 256 accepted.
  - PP count=260; cmd_data_in[2079:2048]=0x02 followed by addr; last byte 0xFF at [7:0].
- Status sequence 0x03, 0x03, 0x01, 0x00 -> exactly 4 RDSR commands, done once, status_out=0x00, error=0.
- POLL_MAX=4, status stuck 0x01 -> exactly 4 RDSR commands, error=1, no done. Next start clears error.
- reset asserted during PP_WAIT -> next cycle busy=0, cmd_trigger=0, wr_ready=0. A fresh start then issues WREN first.
- start pulsed during RDSR_WAIT and wr_valid pulsed outside LOAD -> no effect on addr, N or the command sequence.
